// File: rtl/fifo_frame_ctrl.sv
// fifo_frame_ctrl: pulls bytes from a FIFO one at a time and assembles them into a
// little-endian frame that is held until the downstream shifter accepts it.
module fifo_frame_ctrl #(
  parameter int DSIZE = 8,
  parameter int MAXB  = 15,
  parameter int TMO   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             frame_len,
  input  logic                   fifo_empty,
  input  logic [DSIZE-1:0]       fifo_rdata,
  output logic                   fifo_rinc,
  output logic [DSIZE*MAXB-1:0]  frame_out,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   busy,
  output logic                   err_len,
  output logic                   err_tmo
);
  localparam int TW = $clog2(TMO);
  localparam logic [3:0] MAXL = 4'(MAXB);
  localparam logic [TW-1:0] TLIM = TW'(TMO - 1);
  typedef enum logic [1:0] {IDLE, FETCH, CAPT, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DSIZE*MAXB-1:0] frame_q, frame_d;
  logic rinc_q, rinc_d, valid_q, busy_q;
  logic err_len_q, err_len_d, err_tmo_q, err_tmo_d;
  logic legal;
  assign legal = frame_len != 4'd0 && frame_len <= MAXL;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    frame_d   = frame_q;
    rinc_d    = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        err_len_d = !legal;
        if (legal) begin
          len_d   = frame_len;
          cnt_d   = '0;
          tmo_d   = '0;
          frame_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: if (!fifo_empty) begin
        rinc_d  = 1'b1;
        tmo_d   = '0;
        state_d = CAPT;
      end else if (tmo_q == TLIM) begin
        err_tmo_d = 1'b1;
        frame_d   = '0;
        state_d   = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      CAPT: begin
        frame_d[DSIZE*int'(cnt_q) +: DSIZE] = fifo_rdata;
        state_d = (cnt_q == len_q - 4'd1) ? HOLD : FETCH;
        cnt_d   = (cnt_q == len_q - 4'd1) ? cnt_q : cnt_q + 4'd1;
      end
      default: state_d = frame_ready ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      frame_q   <= '0;
      rinc_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      frame_q   <= frame_d;
      rinc_q    <= rinc_d;
      valid_q   <= state_d == HOLD;
      busy_q    <= state_d != IDLE;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign fifo_rinc   = rinc_q;
  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;
  assign err_len     = err_len_q;
  assign err_tmo     = err_tmo_q;
endmodule

// File: tb/tb_fifo_frame_ctrl.sv
// tb_fifo_frame_ctrl: queue-based FIFO and frame model checked every cycle, plus directed scenarios.
module tb_fifo_frame_ctrl;
  localparam int TMO = 64;
  logic clk = 0, rst = 1, start = 0, start8 = 0, fifo_empty = 1, frame_ready = 0;
  logic [3:0] frame_len = 0;
  logic [7:0] fifo_rdata = 0;
  logic fifo_rinc, frame_valid, busy, err_len, err_tmo;
  logic [119:0] frame_out;
  logic rinc8, valid8, busy8, el8, et8;
  logic [63:0] out8;
  int total = 0, passes = 0, rinc_total = 0, delivered = 0, starve = 0;
  logic [7:0] fq[$];
  logic [7:0] cur[$];
  logic m_busy = 0, m_valid = 0, e_len = 0, e_tmo = 0, e_zero = 0;
  logic rst_e = 0, emp_e = 1, rinc_e = 0, on = 0;
  logic [3:0] m_len = 0;
  logic [7:0] pop_b;

  always #5 clk = ~clk;

  fifo_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rinc(fifo_rinc), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
    .err_len(err_len), .err_tmo(err_tmo));

  fifo_frame_ctrl #(.MAXB(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .frame_len(frame_len), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rinc(rinc8), .frame_out(out8),
    .frame_valid(valid8), .frame_ready(frame_ready), .busy(busy8),
    .err_len(el8), .err_tmo(et8));

  task automatic chk(input string nm, input logic [119:0] got, input logic [119:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  function automatic logic [119:0] exp_frame();
    logic [119:0] r = '0;
    foreach (cur[i]) r[8*i +: 8] = cur[i];
    return r;
  endfunction

  // Model: bytes popped by each strobe are appended to the frame; a frame of len bytes is
  // valid until accepted; TMO consecutive starved cycles abort the frame.
  always @(posedge clk) begin
    rst_e = rst; emp_e = fifo_empty; rinc_e = fifo_rinc;
    e_len = 0; e_tmo = 0; e_zero = 0;
    pop_b = 8'h00;
    if (fifo_rinc) begin
      rinc_total++;
      if (fq.size() > 0) pop_b = fq.pop_front();
    end
    if (frame_valid && frame_ready) delivered++;
    if (rst) begin
      m_busy = 0; m_valid = 0; cur.delete(); e_zero = 1; starve = 0;
    end else if (!m_busy) begin
      if (start && frame_len >= 1 && frame_len <= 15) begin
        m_busy = 1; m_len = frame_len; cur.delete(); starve = 0; e_zero = 1;
      end else if (start) e_len = 1;
    end else if (m_valid) begin
      if (frame_ready) begin m_busy = 0; m_valid = 0; end
    end else if (fifo_rinc) begin
      cur.push_back(pop_b); starve = 0;
      if (cur.size() == int'(m_len)) m_valid = 1;
    end else if (fifo_empty) begin
      starve++;
      if (starve == TMO) begin e_tmo = 1; m_busy = 0; cur.delete(); e_zero = 1; end
    end else starve = 0;
  end

  always @(negedge clk) begin
    #1;
    fifo_empty = fq.size() == 0;
    fifo_rdata = fifo_empty ? 8'h00 : fq[0];
  end

  always @(negedge clk) if (on) begin
    chk("busy", busy, m_busy);
    chk("frame_valid", frame_valid, m_valid);
    chk("err_len", err_len, e_len);
    chk("err_tmo", err_tmo, e_tmo);
    if (m_valid) chk("frame_out", frame_out, exp_frame());
    if (e_zero) chk("frame_clear", frame_out, 0);
    if (rst_e) chk("rinc_rst", fifo_rinc, 0);
    else if (fifo_rinc) chk("rinc_rule", !emp_e && m_busy && !m_valid && !rinc_e, 1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!frame_valid && n < lim) begin tick(1); n++; end
  endtask

  task automatic go(input logic [3:0] len);
    frame_len = len; start = 1; tick(1); start = 0;
  endtask

  task automatic accept();
    frame_ready = 1; tick(1); frame_ready = 0;
    chk("valid_drop", frame_valid, 0);
  endtask

  initial begin
    int n, r0, d0;
    tick(2);
    rst = 0; on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_frame", frame_out, 0);
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    r0 = rinc_total;
    go(3);
    wait_valid(20, n);
    chk("t1_latency", n, 6);
    chk("t1_frame", frame_out, 120'h332211);
    chk("t1_rinc", rinc_total - r0, 3);
    accept();
    for (int i = 1; i <= 15; i++) fq.push_back(8'(i));
    go(15);
    wait_valid(60, n);
    chk("t2_latency", n, 30);
    tick(10);
    chk("t2_hold", frame_valid, 1);
    chk("t2_frame", frame_out, 120'h0F0E0D0C0B0A090807060504030201);
    accept();
    go(0);
    chk("t3_err_len", err_len, 1);
    chk("t3_rinc", fifo_rinc, 0);
    tick(1);
    chk("t3_err_len_once", err_len, 0);
    chk("t3_busy", busy, 0);
    frame_len = 9; start8 = 1; tick(1); start8 = 0;
    chk("t3_err_len8", el8, 1);
    chk("t3_busy8", busy8, 0);
    chk("t3_rinc8", rinc8, 0);
    tick(1);
    chk("t3_err_len8_once", el8, 0);
    chk("t3_busy8_after", busy8, 0);
    fq.push_back(8'hA1); fq.push_back(8'hA2);
    go(4);
    tick(67);
    chk("t4_pre_tmo", err_tmo, 0);
    chk("t4_pre_busy", busy, 1);
    tick(1);
    chk("t4_tmo", err_tmo, 1);
    chk("t4_idle", busy, 0);
    chk("t4_clear", frame_out, 0);
    tick(1);
    chk("t4_tmo_once", err_tmo, 0);
    fq.push_back(8'hA1); fq.push_back(8'hA2);
    go(4);
    tick(67);
    fq.push_back(8'hB3); fq.push_back(8'hB4);
    wait_valid(20, n);
    chk("t4b_frame", frame_out, 120'hB4B3A2A1);
    accept();
    for (int i = 0; i < 5; i++) fq.push_back(8'(8'h51 + i));
    go(5);
    tick(3);
    rst = 1; tick(1); rst = 0;
    chk("t5_busy", busy, 0);
    chk("t5_rinc", fifo_rinc, 0);
    chk("t5_valid", frame_valid, 0);
    chk("t5_errs", {err_len, err_tmo}, 0);
    chk("t5_frame", frame_out, 0);
    fq.delete();
    fq.push_back(8'hA5);
    go(1);
    wait_valid(10, n);
    chk("t5_a5", frame_out, 120'hA5);
    accept();
    fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3);
    r0 = rinc_total; d0 = delivered;
    frame_len = 3; start = 1;
    for (int i = 0; i < 40 && !frame_valid; i++) begin tick(1); start = ~start; end
    chk("t6_frame", frame_out, 120'hC3C2C1);
    frame_ready = 1; start = 1; tick(1);
    frame_ready = 0; start = 0; tick(2);
    chk("t6_idle", busy, 0);
    chk("t6_rinc", rinc_total - r0, 3);
    chk("t6_frames", delivered - d0, 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
